elevator_call_scheduler: RTL and testbench

- Latches hall/cab floor calls and picks the next destination floor using a direction-preserving (collective/SCAN) policy.
- Hands each destination to the existing motion/door controller over a valid/ready handshake, then waits for its arrival pulse.
- Sits between the active-low floor buttons and the elevator state controller, and drives the call-pending lamps.

---
 rtl/elev_sched_pkg.sv | 33 +++
 rtl/elev_next_floor_sel.sv | 50 +++++
 rtl/elevator_call_scheduler.sv | 165 ++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elev_sched_pkg.sv
// Shared types and helpers for the elevator call scheduler.
package elev_sched_pkg;

  localparam int MAX_FLOORS = 16;
  localparam int IDX_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_MOVING,
    ST_HALT
  } state_e;

  function automatic int floor_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic onehot_valid(input logic [MAX_FLOORS-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_FLOORS; i++) cnt += int'(v[i]);
    return cnt == 1;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_FLOORS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_FLOORS; i++) if (v[i]) idx = IDX_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/elev_next_floor_sel.sv
// Combinational SCAN picker: keeps the travel direction while calls remain ahead,
// otherwise reverses. The car's own floor is never a candidate.
module elev_next_floor_sel #(
  parameter int N_FLOORS = 4,
  parameter int FLOOR_W  = 2
) (
  input  logic [N_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]  cur_floor,
  input  logic                dir_up,
  output logic                found,
  output logic [FLOOR_W-1:0]  next_floor,
  output logic                next_dir_up
);

  logic               have_above, have_below;
  logic [FLOOR_W-1:0] lo_above, hi_below;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    have_above = 1'b0;
    have_below = 1'b0;
    lo_above   = '0;
    hi_below   = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending[i] && (i > int'(cur_floor)) && !have_above) begin
        have_above = 1'b1;
        lo_above   = FLOOR_W'(i);
      end
      if (pending[i] && (i < int'(cur_floor))) begin
        have_below = 1'b1;
        hi_below   = FLOOR_W'(i);
      end
    end

    found       = have_above || have_below;
    next_floor  = '0;
    next_dir_up = dir_up;
    if (dir_up && have_above) begin
      next_floor  = lo_above;
      next_dir_up = 1'b1;
    end else if (have_below) begin
      next_floor  = hi_below;
      next_dir_up = 1'b0;
    end else if (have_above) begin
      next_floor  = lo_above;
      next_dir_up = 1'b1;
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Call latch + SCAN destination scheduler with valid/ready hand-off.
// Optional return-home request: define ELEV_SCHED_HOME_RETURN_EN.
module elevator_call_scheduler
  import elev_sched_pkg::*;
#(
  parameter int N_FLOORS = 4,
`ifdef ELEV_SCHED_HOME_RETURN_EN
  parameter int HOME_TIMEOUT = 1000,
`endif
  localparam int FLOOR_W = floor_w(N_FLOORS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] call_n,
  input  logic [N_FLOORS-1:0] floor_sens,
  input  logic                emerg,
  output logic                dest_valid,
  input  logic                dest_ready,
  output logic [FLOOR_W-1:0]  dest_floor,
  output logic                dir_up,
  input  logic                arrived,
  output logic [FLOOR_W-1:0]  cur_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic                dest_valid_q, dest_valid_d;
  logic [FLOOR_W-1:0]  dest_floor_q, dest_floor_d;
  logic                dir_up_q, dir_up_d;
  logic [FLOOR_W-1:0]  cur_floor_q, cur_floor_d;

  logic [N_FLOORS-1:0] call_set, cur_bit, dest_bit, pend_eff, home_vec;
  logic                home_req, home_keep;
  logic                sel_found, sel_dir_up;
  logic [FLOOR_W-1:0]  sel_floor;

  assign call_set = (state_q == ST_HALT) ? '0 : ~call_n;
  assign cur_bit  = N_FLOORS'(1) << cur_floor_q;
  assign dest_bit = N_FLOORS'(1) << dest_floor_q;
  assign home_vec = {{(N_FLOORS-1){1'b0}}, home_req};
  assign pend_eff = pending_q | home_vec;
  // Home request survives an arrival unless that arrival was at floor 0.
  assign home_keep = home_req && (dest_floor_q != '0);

  elev_next_floor_sel #(
    .N_FLOORS(N_FLOORS),
    .FLOOR_W (FLOOR_W)
  ) u_sel (
    .pending    (pend_eff),
    .cur_floor  (cur_floor_q),
    .dir_up     (dir_up_q),
    .found      (sel_found),
    .next_floor (sel_floor),
    .next_dir_up(sel_dir_up)
  );

`ifdef ELEV_SCHED_HOME_RETURN_EN
  localparam int CNT_W = $clog2(HOME_TIMEOUT + 1);
  logic [CNT_W-1:0] idle_cnt_q;
  logic             home_req_q;

  always_ff @(posedge clock) begin
    if (reset || emerg) begin
      idle_cnt_q <= '0;
      home_req_q <= 1'b0;
    end else begin
      if ((state_q == ST_MOVING && arrived && dest_floor_q == '0) ||
          ((state_q == ST_IDLE || state_q == ST_SELECT) && cur_floor_q == '0))
        home_req_q <= 1'b0;
      if (state_q == ST_IDLE && pending_q == '0 && cur_floor_q != '0 &&
          &call_n && !home_req_q) begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
        if (idle_cnt_q == CNT_W'(HOME_TIMEOUT - 1)) home_req_q <= 1'b1;
      end else begin
        idle_cnt_q <= '0;
      end
    end
  end
  assign home_req = home_req_q;
`else
  assign home_req = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | call_set;
    dest_valid_d = dest_valid_q;
    dest_floor_d = dest_floor_q;
    dir_up_d     = dir_up_q;
    cur_floor_d  = cur_floor_q;

    if (onehot_valid(MAX_FLOORS'(floor_sens)))
      cur_floor_d = FLOOR_W'(onehot_to_idx(MAX_FLOORS'(floor_sens)));

    unique case (state_q)
      ST_IDLE: begin
        if (pend_eff == cur_bit) pending_d = (pending_q & ~cur_bit) | call_set;
        else if (pend_eff != '0) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (sel_found) begin
          dest_floor_d = sel_floor;
          dir_up_d     = sel_dir_up;
          dest_valid_d = 1'b1;
          state_d      = ST_ISSUE;
        end else begin
          if (pend_eff == cur_bit) pending_d = (pending_q & ~cur_bit) | call_set;
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (dest_ready) begin
          dest_valid_d = 1'b0;
          state_d      = ST_MOVING;
        end
      end
      ST_MOVING: begin
        if (arrived) begin
          pending_d = pending_d & ~dest_bit;
          state_d   = ((pending_d | (home_keep ? home_vec : '0)) != '0) ? ST_SELECT : ST_IDLE;
        end
      end
      ST_HALT: begin
        pending_d = '0;
        if (!emerg) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (emerg) begin
      state_d      = ST_HALT;
      pending_d    = '0;
      dest_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      dest_valid_q <= 1'b0;
      dest_floor_q <= '0;
      dir_up_q     <= 1'b1;
      cur_floor_q  <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      dest_valid_q <= dest_valid_d;
      dest_floor_q <= dest_floor_d;
      dir_up_q     <= dir_up_d;
      cur_floor_q  <= cur_floor_d;
    end
  end

  assign dest_valid = dest_valid_q;
  assign dest_floor = dest_floor_q;
  assign dir_up     = dir_up_q;
  assign cur_floor  = cur_floor_q;
  assign pending    = pending_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed scenarios plus randomized trips checked against a call-set/SCAN model.
module tb_elevator_call_scheduler;

  localparam int N  = 4;
  localparam int FW = 2;

  logic          clock = 1'b0;
  logic          reset, emerg, dest_ready, arrived;
  logic [N-1:0]  call_n, floor_sens, pending;
  logic          dest_valid, dir_up, busy;
  logic [FW-1:0] dest_floor, cur_floor;

  int n_tests = 0;
  int n_fail  = 0;

  bit [N-1:0] m_pend;
  int         m_cur;
  bit         m_dir;

  always #5 clock = ~clock;

  elevator_call_scheduler #(.N_FLOORS(N)) dut (
    .clock(clock), .reset(reset), .call_n(call_n), .floor_sens(floor_sens),
    .emerg(emerg), .dest_valid(dest_valid), .dest_ready(dest_ready),
    .dest_floor(dest_floor), .dir_up(dir_up), .arrived(arrived),
    .cur_floor(cur_floor), .pending(pending), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic press(input logic [N-1:0] mask);
    call_n = ~mask;
    tick();
    call_n = '1;
  endtask

  task automatic wait_dest(input string tag);
    int c;
    c = 0;
    while (dest_valid !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    if (dest_valid !== 1'b1) check({tag, "_timeout"}, 32'(dest_valid), 32'd1);
  endtask

  task automatic accept(input string tag);
    dest_ready = 1'b1;
    tick();
    dest_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(dest_valid), 32'd0);
    check({tag, "_busy_moving"}, 32'(busy), 32'd1);
  endtask

  task automatic arrive(input int fl);
    floor_sens = N'(1) << fl;
    arrived    = 1'b1;
    tick();
    arrived    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_valid", 32'(dest_valid), 32'd0);
    check("rst_dest", 32'(dest_floor), 32'd0);
    check("rst_dir", 32'(dir_up), 32'd1);
    check("rst_cur", 32'(cur_floor), 32'd0);
    reset = 1'b0;
  endtask

  // Next stop from the set of outstanding calls: keep going while calls lie ahead.
  function automatic int model_pick(input bit [N-1:0] s, input int cur, input bit dir,
                                    output bit nd);
    int above[$];
    int below[$];
    nd = dir;
    for (int f = 0; f < N; f++)
      if (s[f]) begin
        if (f > cur) above.push_back(f);
        else if (f < cur) below.push_back(f);
      end
    if (dir && above.size() > 0) begin nd = 1'b1; return above[0]; end
    if (below.size() > 0) begin nd = 1'b0; return below[below.size()-1]; end
    if (above.size() > 0) begin nd = 1'b1; return above[0]; end
    return -1;
  endfunction

  task automatic random_trip(input int it);
    bit [N-1:0] mask, b;
    bit         nd;
    int         exp, inj;
    mask = N'($urandom_range(1, (1 << N) - 1));
    press(mask);
    m_pend |= mask;
    check($sformatf("r%0d_latch", it), 32'(pending), 32'(m_pend));
    if (m_pend == (N'(1) << m_cur)) begin
      check($sformatf("r%0d_self_busy", it), 32'(busy), 32'd0);
      tick();
      check($sformatf("r%0d_self_clr", it), 32'(pending), 32'd0);
      check($sformatf("r%0d_self_nodest", it), 32'(dest_valid), 32'd0);
      m_pend = '0;
      return;
    end
    while (m_pend != '0) begin
      exp = model_pick(m_pend, m_cur, m_dir, nd);
      if (exp < 0) begin
        tick();
        tick();
        check($sformatf("r%0d_lone_clr", it), 32'(pending), 32'd0);
        m_pend = '0;
        break;
      end
      wait_dest($sformatf("r%0d", it));
      check($sformatf("r%0d_dest", it), 32'(dest_floor), 32'(exp));
      check($sformatf("r%0d_dir", it), 32'(dir_up), 32'(nd));
      m_dir = nd;
      repeat ($urandom_range(0, 3)) begin
        tick();
        check($sformatf("r%0d_hold", it), 32'({dest_valid, dest_floor}), 32'({1'b1, FW'(exp)}));
      end
      accept($sformatf("r%0d", it));
      floor_sens = '0;
      repeat ($urandom_range(1, 3)) tick();
      if ($urandom_range(0, 1) == 1) begin
        inj = $urandom_range(0, N - 1);
        b   = N'(1) << inj;
        press(b);
        m_pend |= b;
        check($sformatf("r%0d_inject", it), 32'(pending), 32'(m_pend));
      end
      check($sformatf("r%0d_cur_hold", it), 32'(cur_floor), 32'(m_cur));
      arrive(exp);
      m_pend &= ~(N'(1) << exp);
      m_cur = exp;
      check($sformatf("r%0d_arr_pend", it), 32'(pending), 32'(m_pend));
      check($sformatf("r%0d_arr_cur", it), 32'(cur_floor), 32'(m_cur));
    end
    check($sformatf("r%0d_idle", it), 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; call_n = '1; floor_sens = 4'b0001; emerg = 1'b0;
    dest_ready = 1'b0; arrived = 1'b0;
    tick();
    do_reset();

    // Single call above: three-cycle latency to dest_valid.
    press(4'b0100);
    check("t1_latch", 32'(pending), 32'b0100);
    tick();
    check("t1_select_busy", 32'(busy), 32'd1);
    check("t1_not_yet", 32'(dest_valid), 32'd0);
    tick();
    check("t1_valid", 32'(dest_valid), 32'd1);
    check("t1_dest", 32'(dest_floor), 32'd2);
    check("t1_dir", 32'(dir_up), 32'd1);
    accept("t1");
    arrive(2);
    check("t1_done_pend", 32'(pending), 32'd0);
    check("t1_done_idle", 32'(busy), 32'd0);

    // Floor sensor holds on multi-hot and all-zero.
    floor_sens = 4'b0010; tick();
    check("cur_onehot", 32'(cur_floor), 32'd1);
    floor_sens = 4'b0110; tick();
    check("cur_multi_hold", 32'(cur_floor), 32'd1);
    floor_sens = 4'b0000; tick();
    check("cur_zero_hold", 32'(cur_floor), 32'd1);
    floor_sens = 4'b0010;

    // Up first, then reverse to the call below (top floor boundary).
    press(4'b1001);
    wait_dest("t2a");
    check("t2_first", 32'(dest_floor), 32'd3);
    check("t2_first_dir", 32'(dir_up), 32'd1);
    accept("t2a");
    arrive(3);
    wait_dest("t2b");
    check("t2_second", 32'(dest_floor), 32'd0);
    check("t2_second_dir", 32'(dir_up), 32'd0);
    accept("t2b");
    arrive(0);
    check("t2_idle", 32'(busy), 32'd0);

    // Call at the current floor is absorbed without a trip.
    floor_sens = 4'b0100; tick();
    press(4'b0100);
    check("t5_busy0", 32'(busy), 32'd0);
    tick();
    check("t5_clr", 32'(pending), 32'd0);
    check("t5_busy1", 32'(busy), 32'd0);
    check("t5_nodest", 32'(dest_valid), 32'd0);

    // Back-pressure: offer stays stable, new call accumulates.
    press(4'b0001);
    wait_dest("t3");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) press(4'b1000);
      else tick();
      check("t3_stable", 32'({dest_valid, dest_floor}), 32'({1'b1, 2'd0}));
    end
    check("t3_pend", 32'(pending), 32'b1001);
    accept("t3");
    dest_ready = 1'b1;
    arrive(0);
    wait_dest("t3r");
    check("t3r_dest", 32'(dest_floor), 32'd3);
    tick();
    check("t3r_one_cycle", 32'(dest_valid), 32'd0);
    dest_ready = 1'b0;

    // Emergency stop during a trip with 1010 pending.
    press(4'b0010);
    check("t4_pend", 32'(pending), 32'b1010);
    emerg = 1'b1;
    tick();
    check("t4_halt_busy", 32'(busy), 32'd1);
    check("t4_halt_pend", 32'(pending), 32'd0);
    check("t4_halt_valid", 32'(dest_valid), 32'd0);
    check("t4_halt_dir", 32'(dir_up), 32'd1);
    press(4'b0100);
    check("t4_ignored", 32'(pending), 32'd0);
    emerg = 1'b0;
    tick();
    check("t4_release", 32'(busy), 32'd0);
    arrived = 1'b1; tick(); arrived = 1'b0;
    check("stray_arrived", 32'({busy, pending}), 32'd0);

    // Randomized trips against the model.
    floor_sens = 4'b0001;
    do_reset();
    m_pend = '0; m_cur = 0; m_dir = 1'b1;
    for (int it = 0; it < 40; it++) random_trip(it);

    // Reset mid-trip after a downward selection.
    floor_sens = 4'b1000;
    do_reset();
    tick();
    press(4'b0010);
    wait_dest("mr");
    check("mr_dir", 32'(dir_up), 32'd0);
    accept("mr");
    floor_sens = '0;
    press(4'b0100);
    reset = 1'b1;
    tick();
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_pend", 32'(pending), 32'd0);
    check("mr_dir_rst", 32'(dir_up), 32'd1);
    check("mr_dest", 32'(dest_floor), 32'd0);
    check("mr_cur", 32'(cur_floor), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
